y_strobe_serializer: RTL and testbench

Hardware counterpart of the bench's per-clock `$strobe("%b", y)` print. It samples the 501-bit `y` vector of a `top` under test and emits it as an ASCII byte stream: one `'0'`/`'1'` character per bit, MSB first, then a newline. Its purpose is to log `y` from an FPGA/emulation build in exactly the same line format the simulation bench prints, so the two logs can be compared line by line. It sits between the `top` instance's `y` output and a byte-wide UART/DMA sink, with a small sample buffer in between.

---
 rtl/y_strobe_serializer.sv | 89 ++++++++
 tb/tb_y_strobe_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/y_strobe_serializer.sv
// y_strobe_serializer: logs each sampled WIDTH-bit vector as ASCII '0'/'1' characters, MSB first, then a newline
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   sample_valid  capture y_in this cycle
//   y_in          vector to log
//   out_data      registered ASCII character
//   out_valid     registered, out_data is valid
//   out_ready     sink accepts the byte
//   busy          FIFO non-empty or a line in progress
//   line_count    completed lines, wraps
//   drop_count    samples lost to a full FIFO, saturates
module y_strobe_serializer #(
  parameter int WIDTH = 501,
  parameter int DEPTH = 2,
  parameter int DROPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] y_in,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      line_count,
  output logic [DROPW-1:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EMIT_BITS, EMIT_NL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [WIDTH-1:0] sr, sr_n;
  logic [IW-1:0] idx, idx_n;
  logic [7:0] data_n;
  logic empty, full, hs, pop, push, drop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign hs = out_valid && out_ready;
  // the head is taken either from IDLE or right at the newline handshake, so lines run back to back
  assign pop = !empty && (state == IDLE || (state == EMIT_NL && hs));
  assign push = sample_valid && (!full || pop);
  assign drop = sample_valid && full && !pop;
  assign busy = !empty || state != IDLE;
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wp] <= y_in;
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      drop_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= 8'h00;
      line_count <= '0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      idx <= idx_n;
      out_valid <= state_n != IDLE;
      out_data <= data_n;
      if (state == EMIT_NL && hs) line_count <= line_count + 1'b1;
    end
  end
  always_comb begin
    state_n = pop ? EMIT_BITS
            : (state == EMIT_BITS && hs && idx == '0) ? EMIT_NL
            : (state == EMIT_NL && hs) ? IDLE : state;
    sr_n = pop ? mem[rp] : sr;
    idx_n = pop ? IW'(WIDTH-1) : (state == EMIT_BITS && hs && idx != '0) ? idx - 1'b1 : idx;
  end
  // next character is derived from next state so the registered byte is stable during a stall
  always_comb begin
    data_n = state_n == EMIT_NL ? 8'h0A : state_n == EMIT_BITS ? {7'b0011000, sr_n[idx_n]} : 8'h00;
  end
endmodule

// File: tb/tb_y_strobe_serializer.sv
// tb_y_strobe_serializer: directed and randomized checks of the serializer against a string-based line model
module tb_y_strobe_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic sv8 = 1'b0, rdy8 = 1'b0, ov8, busy8;
  logic [7:0] y8 = '0, od8, dc8;
  logic [15:0] lc8;
  logic svw = 1'b0, rdyw = 1'b0, ovw, busyw;
  logic [500:0] yw = '0;
  logic [7:0] odw, dcw;
  logic [15:0] lcw;
  int checks = 0, errors = 0, done8 = 0, acc8 = 0, bytesw = 0;
  logic [7:0] exp8[$], expw[$];
  logic [255:0] bench_vec = 256'hb7edf339_5f1c2a48_9e3d7b06_c4a1f852_3e6d90b7_1a5c8e24_f7093b6d_52c8e1a4;

  y_strobe_serializer #(.WIDTH(8), .DEPTH(2), .DROPW(8)) u8 (
    .clk(clk), .rst(rst), .sample_valid(sv8), .y_in(y8), .out_data(od8), .out_valid(ov8),
    .out_ready(rdy8), .busy(busy8), .line_count(lc8), .drop_count(dc8));

  y_strobe_serializer #(.WIDTH(501), .DEPTH(2), .DROPW(8)) uw (
    .clk(clk), .rst(rst), .sample_valid(svw), .y_in(yw), .out_data(odw), .out_valid(ovw),
    .out_ready(rdyw), .busy(busyw), .line_count(lcw), .drop_count(dcw));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic void line8(input logic [7:0] v);
    string s = $sformatf("%b", v);
    for (int i = 0; i < s.len(); i++) exp8.push_back(8'(s[i]));
    exp8.push_back(8'h0A);
  endfunction

  function automatic void linew(input logic [500:0] v);
    string s = $sformatf("%b", v);
    for (int i = 0; i < s.len(); i++) expw.push_back(8'(s[i]));
    expw.push_back(8'h0A);
  endfunction

  task automatic tick();
    #1;
    if (!rst && ov8 && rdy8) begin
      chk("byte8", {24'd0, od8}, exp8.size() != 0 ? {24'd0, exp8.pop_front()} : 32'hxxxxxxxx);
      if (od8 == 8'h0A) done8++;
    end
    if (!rst && ovw && rdyw) begin
      chk("bytew", {24'd0, odw}, expw.size() != 0 ? {24'd0, expw.pop_front()} : 32'hxxxxxxxx);
      bytesw++;
    end
    @(negedge clk);
    sv8 = 1'b0;
    svw = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp8.delete();
    expw.delete();
    done8 = 0;
    acc8 = 0;
    bytesw = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp8.size() + expw.size() != 0; i++) tick();
    chk("drain_left", exp8.size() + expw.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_valid", ov8, 0);
    chk("rst_data", od8, 0);
    chk("rst_lines", lc8, 0);
    chk("rst_drops", dc8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_valid_w", ovw, 0);
    // single line with exact cycle timing
    rdy8 = 1'b1;
    sv8 = 1'b1;
    y8 = 8'hA5;
    line8(8'hA5);
    tick();
    chk("c1_valid", ov8, 0);
    chk("c1_busy", busy8, 1);
    tick();
    chk("c2_valid", ov8, 1);
    chk("c2_data", od8, 8'h31);
    repeat (9) tick();
    chk("c11_lines", lc8, 1);
    chk("c11_busy", busy8, 0);
    chk("c11_left", exp8.size(), 0);
    // backpressure on the first character
    rdy8 = 1'b0;
    sv8 = 1'b1;
    y8 = 8'h80;
    line8(8'h80);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", ov8, 1);
      chk("bp_data", od8, 8'h31);
      tick();
    end
    rdy8 = 1'b1;
    drain(20);
    chk("bp_lines", lc8, 2);
    // back-to-back lines, no idle cycle
    sv8 = 1'b1;
    y8 = 8'hFF;
    line8(8'hFF);
    tick();
    tick();
    sv8 = 1'b1;
    y8 = 8'h00;
    line8(8'h00);
    for (int i = 2; i <= 19; i++) begin
      chk("b2b_valid", ov8, 1);
      tick();
    end
    chk("b2b_lines", lc8, 4);
    chk("b2b_busy", busy8, 0);
    chk("b2b_left", exp8.size(), 0);
    // overflow with the sink stalled
    do_reset();
    rdy8 = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      sv8 = 1'b1;
      y8 = 8'(v);
      tick();
    end
    chk("ovf_drops", dc8, 2);
    line8(8'h01);
    line8(8'h02);
    line8(8'h03);
    rdy8 = 1'b1;
    drain(60);
    chk("ovf_lines", lc8, 3);
    chk("ovf_drops2", dc8, 2);
    // drop counter saturation: 3 accepted then 300 dropped
    do_reset();
    rdy8 = 1'b0;
    repeat (303) begin
      sv8 = 1'b1;
      y8 = 8'($urandom);
      tick();
    end
    chk("sat_drops", dc8, 255);
    do_reset();
    chk("sat_rst", dc8, 0);
    chk("sat_rst_busy", busy8, 0);
    // random traffic and random backpressure, never enough to overflow
    repeat (600) begin
      rdy8 = $urandom_range(0, 3) != 0;
      if (acc8 - done8 < 2 && $urandom_range(0, 7) == 0) begin
        sv8 = 1'b1;
        y8 = 8'($urandom);
        line8(y8);
        acc8++;
      end
      tick();
    end
    rdy8 = 1'b1;
    drain(100);
    chk("rnd_lines", lc8, acc8);
    chk("rnd_drops", dc8, 0);
    // full width: reset in the middle of a line
    do_reset();
    rdyw = 1'b1;
    for (int i = 0; i < 16; i++) yw = (yw << 32) | 501'($urandom);
    svw = 1'b1;
    linew(yw);
    tick();
    for (int i = 0; i < 400 && bytesw < 100; i++) tick();
    chk("w_mid_bytes", bytesw, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expw.delete();
    bytesw = 0;
    chk("w_rst_valid", ovw, 0);
    chk("w_rst_lines", lcw, 0);
    chk("w_rst_busy", busyw, 0);
    tick();
    chk("w_after_rst", bytesw, 0);
    // full width: bench vector line, one byte per cycle
    svw = 1'b1;
    yw = {245'd0, bench_vec};
    linew(yw);
    tick();
    repeat (503) tick();
    chk("w_bytes", bytesw, 502);
    chk("w_lines", lcw, 1);
    chk("w_busy", busyw, 0);
    chk("w_left", expw.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
